led_fade_drv: RTL

Output stage between the LED pattern generator and the board LED pins. It accepts the 8-bit on/off pattern (`led_i`) and drives each LED through an independent brightness ramp, then applies 8-bit PWM, so pattern changes fade in and out instead of switching hard. A bypass input passes the pattern straight through for bring-up.

---
 rtl/led_fade_pkg.sv | 19 +
 rtl/led_fade_ch.sv | 93 +++++++++
 rtl/led_fade_drv.sv | 68 ++++++
 3 files changed

// File: rtl/led_fade_pkg.sv
// Shared types and constants for the LED fade driver.
package led_fade_pkg;

   typedef enum logic [1:0] {
      CH_OFF  = 2'd0,
      CH_RISE = 2'd1,
      CH_ON   = 2'd2,
      CH_FALL = 2'd3
   } ch_state_e;

   localparam logic [7:0] LVL_MAX = 8'hFF;
   localparam int         LED_N   = 8;

   // Full level is solid on; otherwise level k gives k high cycles per period.
   function automatic logic pwm_bit(input logic [7:0] level, input logic [7:0] cnt);
      return (level == LVL_MAX) || (cnt < level);
   endfunction

endpackage

// File: rtl/led_fade_ch.sv
// One LED channel: ramp state machine, brightness level and PWM compare.
module led_fade_ch
   import led_fade_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic       en,
   input  logic       tick,
   input  logic [7:0] pwm_cnt,
   output logic       led_bit,
   output logic       ramping
);

   ch_state_e  state_q, state_d;
   logic [7:0] level_q, level_d;
   logic       led_bit_q, led_bit_d;

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      led_bit_d = pwm_bit(level_q, pwm_cnt);
      if (!en) begin
         if (req) begin
            state_d = CH_ON;
            level_d = LVL_MAX;
         end else begin
            state_d = CH_OFF;
            level_d = 8'h00;
         end
      end else begin
         case (state_q)
            CH_OFF: begin
               if (req) state_d = CH_RISE;
               else     state_d = CH_OFF;
            end
            CH_RISE: begin
               // A request change takes priority over a step in the same cycle.
               if (!req) begin
                  state_d = CH_FALL;
               end else if (tick) begin
                  if (level_q >= (LVL_MAX - 8'd1)) begin
                     level_d = LVL_MAX;
                     state_d = CH_ON;
                  end else begin
                     level_d = level_q + 8'd1;
                  end
               end else begin
                  state_d = CH_RISE;
               end
            end
            CH_ON: begin
               if (!req) state_d = CH_FALL;
               else      state_d = CH_ON;
            end
            CH_FALL: begin
               if (req) begin
                  state_d = CH_RISE;
               end else if (tick) begin
                  if (level_q <= 8'd1) begin
                     level_d = 8'h00;
                     state_d = CH_OFF;
                  end else begin
                     level_d = level_q - 8'd1;
                  end
               end else begin
                  state_d = CH_FALL;
               end
            end
            default: begin
               state_d = CH_OFF;
               level_d = 8'h00;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CH_OFF;
         level_q   <= 8'h00;
         led_bit_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         led_bit_q <= led_bit_d;
      end
   end

   assign led_bit = led_bit_q;
   assign ramping = (state_q == CH_RISE) || (state_q == CH_FALL);

endmodule

// File: rtl/led_fade_drv.sv
// LED output stage: per-channel brightness ramps driven through shared PWM,
// with a bypass that switches the pattern straight through.
module led_fade_drv
   import led_fade_pkg::*;
#(
   parameter int unsigned STEP_DIV = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [LED_N-1:0] led_i,
   input  logic             fade_en,
   output logic [LED_N-1:0] led_o,
   output logic             busy
);

   logic [LED_N-1:0] led_q, led_d;
   logic             en_q, en_d;
   logic [15:0]      presc_q, presc_d;
   logic [7:0]       pwm_q, pwm_d;
   logic             busy_q, busy_d;
   logic             tick_s;
   logic [LED_N-1:0] led_bit_s;
   logic [LED_N-1:0] ramping_s;

   assign tick_s = (presc_q == 16'(STEP_DIV - 1));

   always_comb begin
      led_d  = led_i;
      en_d   = fade_en;
      pwm_d  = pwm_q + 8'd1;
      busy_d = |ramping_s;
      if (tick_s) presc_d = 16'd0;
      else        presc_d = presc_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q   <= '0;
         en_q    <= 1'b0;
         presc_q <= 16'd0;
         pwm_q   <= 8'd0;
         busy_q  <= 1'b0;
      end else begin
         led_q   <= led_d;
         en_q    <= en_d;
         presc_q <= presc_d;
         pwm_q   <= pwm_d;
         busy_q  <= busy_d;
      end
   end

   for (genvar i = 0; i < LED_N; i++) begin : g_ch
      led_fade_ch u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .req     (led_q[i]),
         .en      (en_q),
         .tick    (tick_s),
         .pwm_cnt (pwm_q),
         .led_bit (led_bit_s[i]),
         .ramping (ramping_s[i])
      );
   end

   assign led_o = led_bit_s;
   assign busy  = busy_q;

endmodule
